// File: rtl/id_operand_stage_if.sv
// ID/EX pipeline bus: registered operands and control flowing into EX,
// with EX's allowin travelling back. The ID stage drives the master side.
interface id_operand_stage_if #(
    parameter int CTRL_W = 64
);
    logic              es_valid;
    logic [31:0]       es_pc;
    logic [31:0]       es_src1;
    logic [31:0]       es_src2;
    logic [CTRL_W-1:0] es_ctrl;
    logic              ex_out_allowin;

    modport master (
        output es_valid,
        output es_pc,
        output es_src1,
        output es_src2,
        output es_ctrl,
        input  ex_out_allowin
    );

    modport slave (
        input  es_valid,
        input  es_pc,
        input  es_src1,
        input  es_src2,
        input  es_ctrl,
        output ex_out_allowin
    );
endinterface

// File: rtl/id_operand_stage.sv
// ID operand select + load-use/RAW interlock + ID/EX register.
// Build macro ID_BYPASS_EN enables EX/MEM/WB forwarding; without it operands always come from the regfile.
module id_operand_stage #(
    parameter int CTRL_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ds_valid,
    input  logic [31:0]       ds_pc,
    input  logic [CTRL_W-1:0] ds_ctrl,
    input  logic              rj_used,
    input  logic              rk_used,
    input  logic [1:0]        rj_redirect,
    input  logic [1:0]        rk_redirect,
    input  logic [31:0]       rf_rdata1,
    input  logic [31:0]       rf_rdata2,
    input  logic [31:0]       ex_result,
    input  logic [31:0]       mem_result,
    input  logic [31:0]       wb_result,
    input  logic              ex_is_load,
    input  logic              br_flush,
    output logic              ds_allowin,
    output logic              ds_stall,
    id_operand_stage_if.master es_bus
);

    logic              es_valid_reg;
    logic [31:0]       es_pc_reg;
    logic [31:0]       es_src1_reg;
    logic [31:0]       es_src2_reg;
    logic [CTRL_W-1:0] es_ctrl_reg;

    logic [1:0][31:0]  rf_rdata;
    logic [1:0][1:0]   redirect;
    logic [1:0]        used;
    logic [1:0][31:0]  src_sel;
    logic [1:0]        src_hazard;

    logic hazard;
    logic ds_ready_go;
    logic es_allowin;
    logic ds_to_es_valid;

    assign rf_rdata = {rf_rdata2, rf_rdata1};
    assign redirect = {rk_redirect, rj_redirect};
    assign used     = {rk_used, rj_used};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
`ifdef ID_BYPASS_EN
            logic [31:0] cand [4];
            assign cand[0] = rf_rdata[gi];
            assign cand[1] = ex_result;
            assign cand[2] = mem_result;
            assign cand[3] = wb_result;
            assign src_sel[gi]    = cand[redirect[gi]];
            // Only an EX-stage load cannot be forwarded yet; MEM/WB values are ready.
            assign src_hazard[gi] = used[gi] & (redirect[gi] == 2'b01);
`else
            assign src_sel[gi]    = rf_rdata[gi];
            assign src_hazard[gi] = used[gi] & (redirect[gi] != 2'b00);
`endif
        end
    endgenerate

`ifdef ID_BYPASS_EN
    // es_valid gating lets the bubble cycle clear a stale ex_is_load.
    assign hazard = es_valid_reg & ex_is_load & (|src_hazard);
`else
    logic unused_bypass;
    assign unused_bypass = ^{ex_result, mem_result, wb_result, ex_is_load};
    assign hazard = |src_hazard;
`endif

    assign ds_ready_go    = ~hazard;
    assign ds_stall       = ds_valid & hazard;
    assign es_allowin     = ~es_valid_reg | es_bus.ex_out_allowin;
    assign ds_allowin     = br_flush | ~ds_valid | (ds_ready_go & es_allowin);
    assign ds_to_es_valid = ds_valid & ds_ready_go & ~br_flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            es_valid_reg <= 1'b0;
            es_pc_reg    <= 32'd0;
            es_src1_reg  <= 32'd0;
            es_src2_reg  <= 32'd0;
            es_ctrl_reg  <= '0;
        end else begin
            if (es_allowin) begin
                es_valid_reg <= ds_to_es_valid;
            end
            // Payload holds across bubbles so EX sees stable (but invalid) data.
            if (es_allowin & ds_to_es_valid) begin
                es_pc_reg   <= ds_pc;
                es_src1_reg <= src_sel[0];
                es_src2_reg <= src_sel[1];
                es_ctrl_reg <= ds_ctrl;
            end
        end
    end

    assign es_bus.es_valid = es_valid_reg;
    assign es_bus.es_pc    = es_pc_reg;
    assign es_bus.es_src1  = es_src1_reg;
    assign es_bus.es_src2  = es_src2_reg;
    assign es_bus.es_ctrl  = es_ctrl_reg;

endmodule

// File: tb/tb_id_operand_stage.sv
// Directed bench for id_operand_stage; covers both the bypass and regfile-only builds.
module tb_id_operand_stage;
    localparam int CTRL_W = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic              ds_valid;
    logic [31:0]       ds_pc;
    logic [CTRL_W-1:0] ds_ctrl;
    logic              rj_used, rk_used;
    logic [1:0]        rj_redirect, rk_redirect;
    logic [31:0]       rf_rdata1, rf_rdata2;
    logic [31:0]       ex_result, mem_result, wb_result;
    logic              ex_is_load;
    logic              br_flush;
    logic              ds_allowin;
    logic              ds_stall;

    int total = 0;
    int bad = 0;

    id_operand_stage_if #(.CTRL_W(CTRL_W)) es_bus ();

    id_operand_stage #(.CTRL_W(CTRL_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .ds_valid    (ds_valid),
        .ds_pc       (ds_pc),
        .ds_ctrl     (ds_ctrl),
        .rj_used     (rj_used),
        .rk_used     (rk_used),
        .rj_redirect (rj_redirect),
        .rk_redirect (rk_redirect),
        .rf_rdata1   (rf_rdata1),
        .rf_rdata2   (rf_rdata2),
        .ex_result   (ex_result),
        .mem_result  (mem_result),
        .wb_result   (wb_result),
        .ex_is_load  (ex_is_load),
        .br_flush    (br_flush),
        .ds_allowin  (ds_allowin),
        .ds_stall    (ds_stall),
        .es_bus      (es_bus.master)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ds_valid = 1'b0; br_flush = 1'b0; ex_is_load = 1'b0;
        es_bus.ex_out_allowin = 1'b1;
        rj_used = 1'b0; rk_used = 1'b0; rj_redirect = 2'b00; rk_redirect = 2'b00;
    endtask

    task automatic set_instr(input logic [31:0] pc, input logic [63:0] ctrl,
                             input logic [31:0] r1, input logic [31:0] r2,
                             input logic [1:0] jsel, input logic [1:0] ksel,
                             input logic jused, input logic kused);
        ds_valid = 1'b1; ds_pc = pc; ds_ctrl = ctrl;
        rf_rdata1 = r1; rf_rdata2 = r2;
        rj_redirect = jsel; rk_redirect = ksel; rj_used = jused; rk_used = kused;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        ds_pc = 32'h0; ds_ctrl = '0; rf_rdata1 = 0; rf_rdata2 = 0;
        ex_result = 0; mem_result = 0; wb_result = 0;
        tick(); tick();
        total++; if (es_bus.es_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%h exp=0", es_bus.es_valid); end
        total++; if (es_bus.es_pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=0", es_bus.es_pc); end
        total++; if (es_bus.es_ctrl !== 64'h0) begin bad++; $display("FAIL reset_ctrl got=%h exp=0", es_bus.es_ctrl); end
        reset = 1'b0;
        $display("reset done");
    endtask

    task automatic test_plain_issue();
        set_instr(32'h100, 64'hDEAD_BEEF_0000_0001, 32'h11, 32'h22, 2'b00, 2'b00, 1'b1, 1'b1);
        #1;
        total++; if (ds_allowin !== 1'b1) begin bad++; $display("FAIL plain_allowin got=%h exp=1", ds_allowin); end
        total++; if (ds_stall !== 1'b0) begin bad++; $display("FAIL plain_stall got=%h exp=0", ds_stall); end
        tick();
        total++; if (es_bus.es_valid !== 1'b1) begin bad++; $display("FAIL plain_valid got=%h exp=1", es_bus.es_valid); end
        total++; if (es_bus.es_src1 !== 32'h11) begin bad++; $display("FAIL plain_src1 got=%h exp=11", es_bus.es_src1); end
        total++; if (es_bus.es_src2 !== 32'h22) begin bad++; $display("FAIL plain_src2 got=%h exp=22", es_bus.es_src2); end
        total++; if (es_bus.es_pc !== 32'h100) begin bad++; $display("FAIL plain_pc got=%h exp=100", es_bus.es_pc); end
        total++; if (es_bus.es_ctrl !== 64'hDEAD_BEEF_0000_0001) begin bad++; $display("FAIL plain_ctrl got=%h exp=deadbeef00000001", es_bus.es_ctrl); end
        idle();
        $display("plain issue done: pc=%h", es_bus.es_pc);
    endtask

`ifdef ID_BYPASS_EN
    task automatic test_forwarding();
        ex_result = 32'hA5A50001; mem_result = 32'h0000_3333; wb_result = 32'h5A5A0002;
        set_instr(32'h120, 64'h2, 32'h1, 32'h2, 2'b01, 2'b11, 1'b1, 1'b1);
        #1;
        total++; if (ds_stall !== 1'b0) begin bad++; $display("FAIL fwd_stall got=%h exp=0", ds_stall); end
        tick();
        total++; if (es_bus.es_src1 !== 32'hA5A50001) begin bad++; $display("FAIL fwd_src1 got=%h exp=a5a50001", es_bus.es_src1); end
        total++; if (es_bus.es_src2 !== 32'h5A5A0002) begin bad++; $display("FAIL fwd_src2 got=%h exp=5a5a0002", es_bus.es_src2); end
        idle();
        $display("forwarding done: src1=%h src2=%h", es_bus.es_src1, es_bus.es_src2);
    endtask

    task automatic test_load_use();
        set_instr(32'h400, 64'h40, 32'h0, 32'h0, 2'b00, 2'b00, 1'b0, 1'b0);
        tick();
        set_instr(32'h404, 64'h44, 32'h0, 32'h5555, 2'b00, 2'b01, 1'b0, 1'b1);
        ex_is_load = 1'b1;
        #1;
        total++; if (ds_stall !== 1'b1) begin bad++; $display("FAIL lu_stall got=%h exp=1", ds_stall); end
        total++; if (ds_allowin !== 1'b0) begin bad++; $display("FAIL lu_allowin got=%h exp=0", ds_allowin); end
        tick();
        total++; if (es_bus.es_valid !== 1'b0) begin bad++; $display("FAIL lu_bubble got=%h exp=0", es_bus.es_valid); end
        total++; if (es_bus.es_pc !== 32'h400) begin bad++; $display("FAIL lu_hold_pc got=%h exp=400", es_bus.es_pc); end
        rk_redirect = 2'b10; mem_result = 32'h1234;
        #1;
        total++; if (ds_stall !== 1'b0) begin bad++; $display("FAIL lu_release got=%h exp=0", ds_stall); end
        tick();
        total++; if (es_bus.es_valid !== 1'b1) begin bad++; $display("FAIL lu_valid got=%h exp=1", es_bus.es_valid); end
        total++; if (es_bus.es_src2 !== 32'h1234) begin bad++; $display("FAIL lu_src2 got=%h exp=1234", es_bus.es_src2); end
        total++; if (es_bus.es_pc !== 32'h404) begin bad++; $display("FAIL lu_pc got=%h exp=404", es_bus.es_pc); end
        idle();
        $display("load-use done: src2=%h", es_bus.es_src2);
    endtask
`else
    task automatic test_no_bypass_stall();
        mem_result = 32'h9999;
        set_instr(32'h500, 64'h50, 32'h77, 32'h88, 2'b10, 2'b11, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            #1;
            total++; if (ds_stall !== 1'b1) begin bad++; $display("FAIL nb_stall got=%h exp=1", ds_stall); end
            total++; if (ds_allowin !== 1'b0) begin bad++; $display("FAIL nb_allowin got=%h exp=0", ds_allowin); end
            tick();
            total++; if (es_bus.es_valid !== 1'b0) begin bad++; $display("FAIL nb_bubble got=%h exp=0", es_bus.es_valid); end
        end
        rj_redirect = 2'b00;
        #1;
        total++; if (ds_stall !== 1'b0) begin bad++; $display("FAIL nb_release got=%h exp=0", ds_stall); end
        tick();
        total++; if (es_bus.es_valid !== 1'b1) begin bad++; $display("FAIL nb_valid got=%h exp=1", es_bus.es_valid); end
        total++; if (es_bus.es_src1 !== 32'h77) begin bad++; $display("FAIL nb_src1 got=%h exp=77", es_bus.es_src1); end
        total++; if (es_bus.es_src2 !== 32'h88) begin bad++; $display("FAIL nb_src2 got=%h exp=88", es_bus.es_src2); end
        idle();
        $display("no-bypass stall done: src1=%h", es_bus.es_src1);
    endtask
`endif

    task automatic test_unused_operand();
        logic [31:0] exp1;
`ifdef ID_BYPASS_EN
        exp1 = 32'hE0E0_0001;
`else
        exp1 = 32'h0000_0A0A;
`endif
        set_instr(32'h600, 64'h60, 32'h0, 32'h0, 2'b00, 2'b00, 1'b0, 1'b0);
        tick();
        ex_result = 32'hE0E0_0001; mem_result = 32'hE0E0_0002;
        set_instr(32'h604, 64'h64, 32'h0A0A, 32'h0B0B, 2'b01, 2'b10, 1'b0, 1'b0);
        ex_is_load = 1'b1;
        #1;
        total++; if (ds_stall !== 1'b0) begin bad++; $display("FAIL unused_stall got=%h exp=0", ds_stall); end
        tick();
        total++; if (es_bus.es_valid !== 1'b1) begin bad++; $display("FAIL unused_valid got=%h exp=1", es_bus.es_valid); end
        total++; if (es_bus.es_src1 !== exp1) begin bad++; $display("FAIL unused_src1 got=%h exp=%h", es_bus.es_src1, exp1); end
        idle();
        $display("unused operand done: src1=%h", es_bus.es_src1);
    endtask

    task automatic test_back_pressure();
        set_instr(32'h200, 64'hA, 32'hA1, 32'hA2, 2'b00, 2'b00, 1'b1, 1'b1);
        tick();
        set_instr(32'h204, 64'hB, 32'hB1, 32'hB2, 2'b00, 2'b00, 1'b1, 1'b1);
        es_bus.ex_out_allowin = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (ds_allowin !== 1'b0) begin bad++; $display("FAIL bp_allowin got=%h exp=0", ds_allowin); end
            tick();
            total++; if (es_bus.es_pc !== 32'h200) begin bad++; $display("FAIL bp_hold_pc got=%h exp=200", es_bus.es_pc); end
            total++; if (es_bus.es_src1 !== 32'hA1) begin bad++; $display("FAIL bp_hold_src1 got=%h exp=a1", es_bus.es_src1); end
        end
        es_bus.ex_out_allowin = 1'b1;
        #1;
        total++; if (ds_allowin !== 1'b1) begin bad++; $display("FAIL bp_release got=%h exp=1", ds_allowin); end
        tick();
        total++; if (es_bus.es_pc !== 32'h204) begin bad++; $display("FAIL bp_new_pc got=%h exp=204", es_bus.es_pc); end
        total++; if (es_bus.es_src2 !== 32'hB2) begin bad++; $display("FAIL bp_new_src2 got=%h exp=b2", es_bus.es_src2); end
        idle();
        $display("back-pressure done: pc=%h", es_bus.es_pc);
    endtask

    task automatic test_flush();
        set_instr(32'h300, 64'h30, 32'h3, 32'h4, 2'b00, 2'b00, 1'b1, 1'b1);
        br_flush = 1'b1;
        #1;
        total++; if (ds_allowin !== 1'b1) begin bad++; $display("FAIL fl_allowin got=%h exp=1", ds_allowin); end
        tick();
        total++; if (es_bus.es_valid !== 1'b0) begin bad++; $display("FAIL fl_valid got=%h exp=0", es_bus.es_valid); end
        // Flush while EX is back-pressured: ID drops, ID/EX keeps its instruction.
        br_flush = 1'b0;
        set_instr(32'h310, 64'h31, 32'h5, 32'h6, 2'b00, 2'b00, 1'b1, 1'b1);
        tick();
        set_instr(32'h314, 64'h32, 32'h7, 32'h8, 2'b00, 2'b00, 1'b1, 1'b1);
        es_bus.ex_out_allowin = 1'b0; br_flush = 1'b1;
        #1;
        total++; if (ds_allowin !== 1'b1) begin bad++; $display("FAIL fl_bp_allowin got=%h exp=1", ds_allowin); end
        tick();
        total++; if (es_bus.es_valid !== 1'b1) begin bad++; $display("FAIL fl_bp_valid got=%h exp=1", es_bus.es_valid); end
        total++; if (es_bus.es_pc !== 32'h310) begin bad++; $display("FAIL fl_bp_pc got=%h exp=310", es_bus.es_pc); end
        // Flush together with a hazard (load-use or non-regfile select).
        set_instr(32'h318, 64'h33, 32'h9, 32'hA, 2'b00, 2'b01, 1'b0, 1'b1);
        es_bus.ex_out_allowin = 1'b1; ex_is_load = 1'b1; br_flush = 1'b1;
        #1;
        total++; if (ds_stall !== 1'b1) begin bad++; $display("FAIL fl_hz_stall got=%h exp=1", ds_stall); end
        total++; if (ds_allowin !== 1'b1) begin bad++; $display("FAIL fl_hz_allowin got=%h exp=1", ds_allowin); end
        tick();
        total++; if (es_bus.es_valid !== 1'b0) begin bad++; $display("FAIL fl_hz_valid got=%h exp=0", es_bus.es_valid); end
        idle();
        $display("flush done");
    endtask

    task automatic test_reset_mid();
        set_instr(32'h700, 64'hFF, 32'hFFFF, 32'hEEEE, 2'b00, 2'b00, 1'b1, 1'b1);
        tick();
        total++; if (es_bus.es_src1 !== 32'hFFFF) begin bad++; $display("FAIL rm_pre_src1 got=%h exp=ffff", es_bus.es_src1); end
        set_instr(32'h704, 64'hEE, 32'h1234, 32'h5678, 2'b00, 2'b00, 1'b1, 1'b1);
        reset = 1'b1;
        tick();
        total++; if (es_bus.es_valid !== 1'b0) begin bad++; $display("FAIL rm_valid got=%h exp=0", es_bus.es_valid); end
        total++; if (es_bus.es_pc !== 32'h0) begin bad++; $display("FAIL rm_pc got=%h exp=0", es_bus.es_pc); end
        total++; if (es_bus.es_src1 !== 32'h0) begin bad++; $display("FAIL rm_src1 got=%h exp=0", es_bus.es_src1); end
        total++; if (es_bus.es_src2 !== 32'h0) begin bad++; $display("FAIL rm_src2 got=%h exp=0", es_bus.es_src2); end
        total++; if (es_bus.es_ctrl !== 64'h0) begin bad++; $display("FAIL rm_ctrl got=%h exp=0", es_bus.es_ctrl); end
        reset = 1'b0;
        idle();
        $display("reset mid-op done");
    endtask

    initial begin
        test_reset();
        test_plain_issue();
`ifdef ID_BYPASS_EN
        test_forwarding();
        test_load_use();
`else
        test_no_bypass_stall();
`endif
        test_unused_operand();
        test_back_pressure();
        test_flush();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/id_operand_stage.md
# id_operand_stage

ID-stage operand selection and ID/EX pipeline register for the 5-stage LoongArch core. Consumes the per-operand forwarding selects computed in ID, picks each source from the register file or the EX/MEM/WB results, and applies the load-use interlock. Holds the ID/EX register under a valid/allowin handshake, with branch flush from EX. Sits between the IF/ID register and the EX stage.

## Interface
- CTRL_W, 64, width of the opaque decoded-control bundle passed to EX
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- ds_valid  in  1  IF/ID register holds a valid instruction
- ds_pc  in  32  PC of ID instruction
- ds_ctrl  in  CTRL_W  decoded control bundle of ID instruction
- rj_used / rk_used  in  1 each  instruction actually reads rj / rk (rd for stores/branches)
- rj_redirect / rk_redirect  in  2 each  forward select: 00 regfile, 01 EX, 10 MEM, 11 WB
- rf_rdata1 / rf_rdata2  in  32 each  regfile read data for rj / rk
- ex_result / mem_result / wb_result  in  32 each  forwarded results
- ex_is_load  in  1  instruction in EX is a load (raw, this block gates with es_valid)
- ex_out_allowin  in  1  EX can hand its current instruction to MEM this cycle
- br_flush  in  1  branch taken in EX; kill ID instruction
- ds_allowin  out  1  IF/ID may load a new instruction
- ds_stall  out  1  ID instruction is being held by a hazard
- es_valid  out  1  ID/EX register valid
- es_pc  out  32  registered PC
- es_src1 / es_src2  out  32 each  registered rj / rk operand values
- es_ctrl  out  CTRL_W  registered control bundle

## Operation
- Operand mux per source: 00 rf_rdata, 01 ex_result, 10 mem_result, 11 wb_result. Pure 32-bit select; no arithmetic.
- load_use = es_valid & ex_is_load & ((rj_used & rj_redirect==01) | (rk_used & rk_redirect==01)).
- hazard = load_use (bypass build, see Configuration).
- ds_ready_go = ~hazard; ds_stall = ds_valid & hazard.
- es_allowin = ~es_valid | ex_out_allowin (internal).
- ds_allowin = br_flush | ~ds_valid | (ds_ready_go & es_allowin).
- ds_to_es_valid = ds_valid & ds_ready_go & ~br_flush.
- Register update on clk:
  - reset: es_valid, es_pc, es_src1, es_src2, es_ctrl all 0.
  - else if es_allowin: es_valid <= ds_to_es_valid.
  - es_pc/es_src*/es_ctrl load only when es_allowin & ds_to_es_valid; otherwise hold, including while a bubble is inserted.
- Unused operand (rj_used=0): select still applied, never causes a stall.
- br_flush with es_allowin=0: ID instruction is still discarded (ds_allowin=1, IF/ID drops it); ID/EX content untouched.

## Timing
- One-cycle latency: instruction accepted at edge N appears on es_* after edge N.
- ds_allowin, ds_stall combinational from same-cycle inputs; es_* registered only.
- Load-use costs exactly one bubble: next cycle the load is in MEM (select becomes 10), es_valid=0 after bubble so ex_is_load is gated off.
- Simultaneous hazard and br_flush: flush wins; no bubble bookkeeping, ds_allowin=1.
- Simultaneous reset and any input: reset wins.
- Back-pressure (ex_out_allowin=0, es_valid=1): es_* hold; ds_allowin=0 if ds_valid.

## Configuration
- ID_BYPASS_EN defined: behaviour as above; only load-use stalls.
- ID_BYPASS_EN undefined: no forwarding; operand mux forced to regfile data; hazard = (rj_used & rj_redirect!=00) | (rk_used & rk_redirect!=00); instruction stalls until both used selects read 00. es_valid gating of ex_is_load unused.

## Test plan
- Plain issue: ds_valid=1, selects 00, rf_rdata1=0x11, rf_rdata2=0x22, ex_out_allowin=1 -> next cycle es_valid=1, es_src1=0x11, es_src2=0x22, ds_allowin was 1.
- Forwarding: rj_redirect=01 ex_result=0xA5A50001, rk_redirect=11 wb_result=0x5A5A0002, ex_is_load=0 -> es_src1=0xA5A50001, es_src2=0x5A5A0002, no stall.
- Load-use: es_valid=1, ex_is_load=1, rk_used=1, rk_redirect=01 -> ds_stall=1, ds_allowin=0, next es_valid=0; next cycle rk_redirect=10 mem_result=0x1234 -> es_src2=0x1234.
- Back-pressure: es_valid=1, ex_out_allowin=0 for 3 cycles -> es_* unchanged, ds_allowin=0; release -> new instruction loads.
- Flush: ds_valid=1, br_flush=1, ex_out_allowin=1 -> ds_allowin=1, next es_valid=0; also with load_use asserted same cycle.
- Reset mid-op: reset=1 while es_valid=1, es_src1=0xFFFF -> after edge all es_* = 0; macro-off build: rj_redirect=10, rj_used=1 -> ds_stall=1 until select 00, then es_src1=rf_rdata1.
